// File: rtl/key_pkg.sv
// Shared definitions for the key press generator and the key-input FSMs.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } kpg_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (dec && (value_reg != '0)) begin
      value_reg <= value_reg - 1'b1;
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);

endmodule

// File: rtl/key_press_gen.sv
// Turns 1-cycle requests into queued active-low key press waveforms:
// HOLD_CYCLES low, then GAP_CYCLES high, back to back while work is queued.
module key_press_gen
  import key_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_PEND    = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  output logic                          key_out,
  output logic                          busy,
  output logic [$clog2(MAX_PEND+1)-1:0] pending,
  output logic                          drop
);

  localparam int TW_RAW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES));
  localparam int TW     = (TW_RAW > 0) ? TW_RAW : 1;
  localparam int PW     = $clog2(MAX_PEND + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

  kpg_state_t    state_reg, state_next;
  logic [PW-1:0] pending_reg, pending_next;
  logic          drop_reg, drop_next;

  logic          start;
  logic          consume;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_value;
  logic          tmr_dec;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .dec        (tmr_dec),
    .value      (tmr_value),
    .zero       (tmr_zero)
  );

  // Queued work counts as a start just like a fresh request.
  assign start = req | (pending_reg != '0);

  always_comb begin
    state_next     = state_reg;
    tmr_load       = 1'b0;
    tmr_load_value = HOLD_LOAD;
    tmr_dec        = 1'b0;
    consume        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PRESS;
          tmr_load   = 1'b1;
          consume    = 1'b1;
        end
      end
      PRESS: begin
        if (tmr_zero) begin
          state_next     = RELEASE;
          tmr_load       = 1'b1;
          tmr_load_value = GAP_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RELEASE: begin
        if (tmr_zero) begin
          if (start) begin
            state_next = PRESS;
            tmr_load   = 1'b1;
            consume    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A request arriving on a consume cycle takes the consumed slot.
  always_comb begin
    pending_next = pending_reg;
    drop_next    = 1'b0;
    if (req && !consume) begin
      if (pending_reg < PEND_MAX) begin
        pending_next = pending_reg + 1'b1;
      end else begin
        drop_next = 1'b1;
      end
    end else if (!req && consume && (pending_reg != '0)) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      drop_reg    <= drop_next;
    end
  end

  assign key_out = (state_reg != PRESS);
  assign busy    = (state_reg != IDLE);
  assign pending = pending_reg;
  assign drop    = drop_reg;

endmodule

// File: tb/tb_key_press_gen.sv
// Directed and random checks of key_press_gen with HOLD=3, GAP=2, MAX_PEND=2.
module tb_key_press_gen;

  localparam int H  = 3;
  localparam int G  = 2;
  localparam int MP = 2;
  localparam int PW = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0;
  logic          key_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          drop;

  key_press_gen #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PEND    (MP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .key_out (key_out),
    .busy    (busy),
    .pending (pending),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waveform scoreboard for the random phase
  int prev_key, run_len, bad_low, bad_high, presses, drops, reqs;
  bit seen_idle, had_press;

  task automatic monitor();
    if (drop) drops++;
    if (int'(key_out) == prev_key) begin
      run_len++;
    end else begin
      if (prev_key == 0) begin
        if (run_len != H) bad_low++;
      end else begin
        presses++;
        if (had_press && !seen_idle && run_len != G) bad_high++;
        had_press = 1'b1;
        seen_idle = 1'b0;
      end
      prev_key = int'(key_out);
      run_len  = 1;
    end
    if (!busy) seen_idle = 1'b1;
  endtask

  logic [5:0]  t2_key  = 6'b111000;
  logic [5:0]  t2_busy = 6'b011111;
  logic [15:0] t3_req  = 16'h000F;
  logic [15:0] t3_key  = 16'hE318;
  logic [15:0] t3_busy = 16'h7FFF;
  logic [15:0] t3_drop = 16'h0008;
  int          t3_pend [16] = '{0, 1, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  logic [15:0] t4_req  = 16'h0027;

  initial begin
    int cnt;
    int falls;
    int lows;
    logic prev;

    // Reset held over three edges
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key", key_out, 1);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_drop", drop, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single request
    for (int k = 0; k < 6; k++) begin
      req = (k == 0);
      step();
      check($sformatf("t2_key[%0d]", k), key_out, t2_key[k]);
      check($sformatf("t2_busy[%0d]", k), busy, t2_busy[k]);
    end
    req = 1'b0;

    // Four consecutive requests: three presses, one drop
    for (int k = 0; k < 16; k++) begin
      req = t3_req[k];
      step();
      check($sformatf("t3_key[%0d]", k), key_out, t3_key[k]);
      check($sformatf("t3_busy[%0d]", k), busy, t3_busy[k]);
      check($sformatf("t3_drop[%0d]", k), drop, t3_drop[k]);
      check($sformatf("t3_pend[%0d]", k), pending, t3_pend[k]);
    end
    req = 1'b0;

    // Request on the consume edge with a full queue
    for (int k = 0; k < 6; k++) begin
      req = t4_req[k];
      step();
      if (k == 2) check("t4_pend_full", pending, 2);
      if (k == 4) check("t4_key_gap", key_out, 1);
    end
    req = 1'b0;
    check("t4_pend_kept", pending, 2);
    check("t4_key_start", key_out, 0);
    check("t4_no_drop", drop, 0);
    cnt   = 0;
    falls = 0;
    prev  = key_out;
    while ((busy || pending != 0) && cnt < 60) begin
      step();
      if (prev && !key_out) falls++;
      prev = key_out;
      cnt++;
    end
    check("t4_drain_busy", busy, 0);
    check("t4_drain_pend", pending, 0);
    check("t4_drain_presses", falls, 2);
    check("t4_drain_cycles", cnt, 15);

    // Asynchronous reset mid-press with one queued request
    req = 1'b1;
    step();
    step();
    req = 1'b0;
    check("t5_pre_pend", pending, 1);
    check("t5_pre_key", key_out, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_key", key_out, 1);
    check("t5_rst_pend", pending, 0);
    check("t5_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!key_out || busy) lows++;
    end
    check("t5_no_ghost_press", lows, 0);

    // Random stream with scoreboard
    prev_key  = int'(key_out);
    run_len   = 0;
    bad_low   = 0;
    bad_high  = 0;
    presses   = 0;
    drops     = 0;
    reqs      = 0;
    seen_idle = 1'b1;
    had_press = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      req = ($urandom_range(0, 3) == 0);
      if (req) reqs++;
      step();
      monitor();
    end
    req = 1'b0;
    cnt = 0;
    while ((busy || pending != 0) && cnt < 100) begin
      step();
      monitor();
      cnt++;
    end
    check("rnd_idle", busy, 0);
    check("rnd_conserve", presses + drops, reqs);
    check("rnd_low_runs", bad_low, 0);
    check("rnd_high_runs", bad_high, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
